// File: rtl/nmcu_pkg.sv
// Shared types and width helpers for the NMCU memory arbiter.
package nmcu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } arb_state_t;

    localparam int NUM_REQ_DEFAULT = 4;

    // Index width for n items; never below 1 so that vectors stay legal.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nmcu_mem_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above
// the pointer, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_found
);

    logic [IDX_W:0]   w_sum  [NUM_REQ];
    logic [IDX_W-1:0] w_cand [NUM_REQ];
    logic [NUM_REQ-1:0] w_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign w_sum[gi]  = {1'b0, i_ptr} + (IDX_W+1)'(gi);
            assign w_cand[gi] = (w_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                              ? IDX_W'(w_sum[gi] - (IDX_W+1)'(NUM_REQ))
                              : w_sum[gi][IDX_W-1:0];
            assign w_hit[gi]  = i_req[w_cand[gi]];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest hit wins last.
    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_found  = 1'b1;
                o_winner = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/nmcu_mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between NMCU requesters,
// with bounded lock bursts and a watchdog that aborts stalled transactions.
module nmcu_mem_arbiter
    import nmcu_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEFAULT,
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BURST      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_we,
    input  logic [NUM_REQ-1:0]                   req_lock,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                   req_ack,
    output logic [NUM_REQ-1:0]                   req_err,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic [idx_width(NUM_REQ)-1:0]        grant_id,
    output logic                                 busy,
    output logic                                 mem_sel,
    output logic                                 mem_w,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    input  logic                                 mem_ready,
    input  logic [DATA_WIDTH-1:0]                mem_rdata
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int TW    = idx_width(TIMEOUT_CYCLES);
    localparam int BW    = idx_width(MAX_BURST);

    arb_state_t              r_state,     w_state_next;
    logic [IDX_W-1:0]        r_rr_ptr,    w_rr_ptr_next;
    logic [BW-1:0]           r_burst_cnt, w_burst_cnt_next;
    logic [TW-1:0]           r_timer,     w_timer_next;
    logic                    r_lock,      w_lock_next;
    logic [NUM_REQ-1:0]      r_ack,       w_ack_next;
    logic [NUM_REQ-1:0]      r_err,       w_err_next;
    logic [DATA_WIDTH-1:0]   r_rd_data,   w_rd_data_next;
    logic [IDX_W-1:0]        r_grant_id,  w_grant_id_next;
    logic                    r_busy,      w_busy_next;
    logic                    r_mem_sel,   w_mem_sel_next;
    logic                    r_mem_w,     w_mem_w_next;
    logic [ADDR_WIDTH-1:0]   r_mem_addr,  w_mem_addr_next;
    logic [DATA_WIDTH-1:0]   r_mem_wdata, w_mem_wdata_next;

    logic [IDX_W-1:0]        w_winner;
    logic                    w_found;
    logic [IDX_W-1:0]        w_grant_inc;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    assign w_grant_inc = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_timer     <= '0;
            r_lock      <= 1'b0;
            r_ack       <= '0;
            r_err       <= '0;
            r_rd_data   <= '0;
            r_grant_id  <= '0;
            r_busy      <= 1'b0;
            r_mem_sel   <= 1'b0;
            r_mem_w     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rr_ptr    <= w_rr_ptr_next;
            r_burst_cnt <= w_burst_cnt_next;
            r_timer     <= w_timer_next;
            r_lock      <= w_lock_next;
            r_ack       <= w_ack_next;
            r_err       <= w_err_next;
            r_rd_data   <= w_rd_data_next;
            r_grant_id  <= w_grant_id_next;
            r_busy      <= w_busy_next;
            r_mem_sel   <= w_mem_sel_next;
            r_mem_w     <= w_mem_w_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_rr_ptr_next    = r_rr_ptr;
        w_burst_cnt_next = r_burst_cnt;
        w_timer_next     = r_timer;
        w_lock_next      = r_lock;
        w_ack_next       = '0;
        w_err_next       = '0;
        w_rd_data_next   = r_rd_data;
        w_grant_id_next  = r_grant_id;
        w_busy_next      = r_busy;
        w_mem_sel_next   = r_mem_sel;
        w_mem_w_next     = r_mem_w;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_mem_sel_next   = 1'b1;
                    w_mem_w_next     = req_we[w_winner];
                    w_mem_addr_next  = req_addr[w_winner];
                    w_mem_wdata_next = req_wdata[w_winner];
                    w_lock_next      = req_lock[w_winner];
                    w_grant_id_next  = w_winner;
                    w_timer_next     = '0;
                    w_busy_next      = 1'b1;
                    w_state_next     = BUSY;
                    // A held lock leaves the pointer on its owner, so any other
                    // winner means the burst has been broken.
                    if (w_winner != r_rr_ptr) begin
                        w_burst_cnt_next = '0;
                    end
                end
            end

            BUSY: begin
                if (mem_ready) begin
                    w_rd_data_next             = mem_rdata;
                    w_ack_next[r_grant_id]     = 1'b1;
                    w_mem_sel_next             = 1'b0;
                    w_mem_w_next               = 1'b0;
                    w_state_next               = RECOVER;
                    if (r_lock && (r_burst_cnt < BW'(MAX_BURST - 1))) begin
                        w_rr_ptr_next    = r_grant_id;
                        w_burst_cnt_next = r_burst_cnt + 1'b1;
                    end else begin
                        w_rr_ptr_next    = w_grant_inc;
                        w_burst_cnt_next = '0;
                    end
                end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_err_next[r_grant_id] = 1'b1;
                    w_mem_sel_next         = 1'b0;
                    w_mem_w_next           = 1'b0;
                    w_rr_ptr_next          = w_grant_inc;
                    w_burst_cnt_next       = '0;
                    w_state_next           = RECOVER;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end

            RECOVER: begin
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end

            default: begin
                w_mem_sel_next = 1'b0;
                w_mem_w_next   = 1'b0;
                w_busy_next    = 1'b0;
                w_state_next   = IDLE;
            end
        endcase
    end

    assign req_ack   = r_ack;
    assign req_err   = r_err;
    assign rd_data   = r_rd_data;
    assign grant_id  = r_grant_id;
    assign busy      = r_busy;
    assign mem_sel   = r_mem_sel;
    assign mem_w     = r_mem_w;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_nmcu_mem_arbiter.sv
// Directed bench for nmcu_mem_arbiter: a bench-driven memory answers each
// grant, and every scenario checks against hand-computed expectations.
module tb_nmcu_mem_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        req_valid, req_we, req_lock;
    logic [3:0][15:0]  req_addr;
    logic [3:0][31:0]  req_wdata;
    logic [3:0]        req_ack, req_err;
    logic [31:0]       rd_data;
    logic [1:0]        grant_id;
    logic              busy, mem_sel, mem_w;
    logic [15:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    nmcu_mem_arbiter #(
        .NUM_REQ(4), .ADDR_WIDTH(16), .DATA_WIDTH(32),
        .MAX_BURST(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_err(req_err), .rd_data(rd_data),
        .grant_id(grant_id), .busy(busy),
        .mem_sel(mem_sel), .mem_w(mem_w), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0; mem_rdata = '0;
        req_valid = '0; req_we = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Bench-side memory: wait for a grant, stall wait_cyc cycles, then return
    // ready; ends in the RECOVER cycle where the ack is visible. gid=-1 if no grant.
    task automatic serve(input int wait_cyc, input logic [31:0] rdat,
                         output int gid, output logic [3:0] ackv, output int lo);
        lo = 0; gid = -1; ackv = '0;
        for (int i = 0; i < 20 && !mem_sel; i++) begin
            lo++;
            @(negedge clk);
        end
        if (!mem_sel) return;
        gid = int'(grant_id);
        repeat (wait_cyc) @(negedge clk);
        mem_ready = 1'b1; mem_rdata = rdat;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = '0;
        ackv = req_ack;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b0; mem_rdata = '0;
        req_valid = '0; req_we = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0;
        @(negedge clk);
        n_vec++;
        if ({mem_sel, mem_w, busy} !== 3'b000) begin
            n_err++; $display("FAIL reset_ctrl got sel/w/busy=%b want 000", {mem_sel, mem_w, busy});
        end
        n_vec++;
        if ({req_ack, req_err, grant_id} !== 10'd0) begin
            n_err++; $display("FAIL reset_pulses got ack=%b err=%b gid=%0d want 0", req_ack, req_err, grant_id);
        end
        n_vec++;
        if ({mem_addr, mem_wdata, rd_data} !== 80'd0) begin
            n_err++; $display("FAIL reset_data got addr=%h wdata=%h rd=%h want 0", mem_addr, mem_wdata, rd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: sel=%b busy=%b gid=%0d", mem_sel, busy, grant_id);
    endtask

    task automatic test_single_read();
        do_reset();
        req_addr[1] = 16'h0040; req_we = '0; req_valid = 4'b0010;
        @(negedge clk);
        n_vec++;
        if ({mem_sel, mem_w, mem_addr, grant_id, busy} !== {1'b1, 1'b0, 16'h0040, 2'd1, 1'b1}) begin
            n_err++; $display("FAIL read_grant got sel=%b w=%b addr=%h gid=%0d busy=%b want 1 0 0040 1 1",
                              mem_sel, mem_w, mem_addr, grant_id, busy);
        end
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = '0;
        n_vec++;
        if ({req_ack, req_err, mem_sel, busy} !== {4'b0010, 4'b0000, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL read_ack got ack=%b err=%b sel=%b busy=%b want 0010 0000 0 1",
                              req_ack, req_err, mem_sel, busy);
        end
        n_vec++;
        if (rd_data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL read_data got %h want deadbeef", rd_data);
        end
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if ({req_ack, busy, rd_data} !== {4'b0000, 1'b0, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL read_after got ack=%b busy=%b rd=%h want 0000 0 deadbeef", req_ack, busy, rd_data);
        end
        $display("single_read: addr=%h rd_data=%h", mem_addr, rd_data);
    endtask

    task automatic test_contention();
        int gid, lo;
        logic [3:0] ackv;
        int exp_id [2] = '{0, 2};
        do_reset();
        req_valid = 4'b0101;
        for (int t = 0; t < 2; t++) begin
            serve(0, 32'h1000 + t, gid, ackv, lo);
            n_vec++;
            if (gid !== exp_id[t] || ackv !== (4'b0001 << exp_id[t])) begin
                n_err++; $display("FAIL contention_%0d got gid=%0d ack=%b want gid=%0d", t, gid, ackv, exp_id[t]);
            end
            // Gap between grants is the RECOVER cycle plus the arbitrating IDLE cycle.
            if (t == 1) begin
                n_vec++;
                if (lo !== 2) begin
                    n_err++; $display("FAIL contention_gap got %0d low cycles want 2", lo);
                end
            end
            req_valid = req_valid & ~ackv;
            $display("contention: txn %0d gid=%0d ack=%b gap=%0d", t, gid, ackv, lo);
        end
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int gid, lo;
        logic [3:0] ackv;
        do_reset();
        req_valid = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            serve(0, 32'h2000 + t, gid, ackv, lo);
            n_vec++;
            if (gid !== (t % 4) || ackv !== (4'b0001 << (t % 4))) begin
                n_err++; $display("FAIL fairness_%0d got gid=%0d ack=%b want gid=%0d", t, gid, ackv, t % 4);
            end
            $display("fairness: txn %0d gid=%0d", t, gid);
        end
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_lock_limit();
        int gid, lo;
        logic [3:0] ackv;
        int exp_id [5] = '{3, 3, 3, 3, 0};
        do_reset();
        // One transaction by requester 2 leaves the pointer at 3.
        req_valid = 4'b0100;
        serve(0, 32'h0, gid, ackv, lo);
        req_valid = 4'b1001; req_lock = 4'b1000;
        for (int t = 0; t < 5; t++) begin
            serve(0, 32'h3000 + t, gid, ackv, lo);
            n_vec++;
            if (gid !== exp_id[t]) begin
                n_err++; $display("FAIL lock_%0d got gid=%0d want %0d", t, gid, exp_id[t]);
            end
            $display("lock_limit: txn %0d gid=%0d", t, gid);
        end
        req_valid = '0; req_lock = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int gid, lo, hi_cnt;
        logic [3:0] ackv;
        do_reset();
        req_addr[2] = 16'h1234; req_wdata[2] = 32'h5; req_we = 4'b0100;
        req_valid = 4'b1100;
        @(negedge clk);
        n_vec++;
        if ({mem_sel, mem_w, mem_addr, mem_wdata, grant_id} !== {1'b1, 1'b1, 16'h1234, 32'h5, 2'd2}) begin
            n_err++; $display("FAIL timeout_grant got sel=%b w=%b addr=%h wdata=%h gid=%0d want 1 1 1234 5 2",
                              mem_sel, mem_w, mem_addr, mem_wdata, grant_id);
        end
        hi_cnt = 0;
        for (int i = 0; i < 200 && mem_sel; i++) begin
            n_vec++;
            if (req_ack !== 4'b0000) begin
                n_err++; $display("FAIL timeout_noack cycle %0d got ack=%b want 0000", i, req_ack);
            end
            hi_cnt++;
            @(negedge clk);
        end
        n_vec++;
        if (hi_cnt !== 64 || req_err !== 4'b0100 || req_ack !== 4'b0000 || mem_w !== 1'b0) begin
            n_err++; $display("FAIL timeout_err got busy_cycles=%0d err=%b ack=%b w=%b want 64 0100 0000 0",
                              hi_cnt, req_err, req_ack, mem_w);
        end
        n_vec++;
        if (rd_data !== 32'h0) begin
            n_err++; $display("FAIL timeout_rd got %h want 0", rd_data);
        end
        $display("timeout: busy_cycles=%0d err=%b", hi_cnt, req_err);
        req_valid = 4'b1000; req_we = '0;
        serve(0, 32'h4, gid, ackv, lo);
        n_vec++;
        if (gid !== 3 || ackv !== 4'b1000) begin
            n_err++; $display("FAIL timeout_next got gid=%0d ack=%b want 3 1000", gid, ackv);
        end
        $display("timeout: next gid=%0d", gid);
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_ready_at_timeout();
        do_reset();
        req_valid = 4'b0010;
        @(negedge clk);
        repeat (63) @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = '0;
        n_vec++;
        if (req_ack !== 4'b0010 || req_err !== 4'b0000 || rd_data !== 32'h0BADF00D) begin
            n_err++; $display("FAIL ready_at_timeout got ack=%b err=%b rd=%h want 0010 0000 0badf00d",
                              req_ack, req_err, rd_data);
        end
        $display("ready_at_timeout: ack=%b err=%b", req_ack, req_err);
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int gid, lo;
        logic [3:0] ackv;
        logic [3:0] seen;
        do_reset();
        req_valid = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (mem_sel !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_async got sel=%b busy=%b want 0 0", mem_sel, busy);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = 4'b0010;
        seen = '0;
        seen = seen | req_ack | req_err;
        serve(0, 32'h77, gid, ackv, lo);
        n_vec++;
        if (seen !== 4'b0000 || gid !== 1 || ackv !== 4'b0010) begin
            n_err++; $display("FAIL reset_regrant got stray=%b gid=%0d ack=%b want 0000 1 0010", seen, gid, ackv);
        end
        $display("reset_mid_busy: first gid=%0d", gid);
        req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_fairness();
        test_lock_limit();
        test_timeout();
        test_ready_at_timeout();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
